// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// dmem_pkg : shared types and helpers for the MEM-stage data memory port
// Rev 1.0  : initial release
// ============================================================================
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } dmem_size_e;

    localparam int MAX_OFF_W = 3;

    // Control half of one read-pipeline stage; the raw word is kept alongside
    // because its width follows DATA_W.
    typedef struct packed {
        logic                 vld;
        logic                 err;
        logic                 we;
        logic [1:0]           size;
        logic                 sgn;
        logic [MAX_OFF_W-1:0] off;
    } dmem_stage_t;

    function automatic logic [7:0] lane_mask(input logic [1:0] size,
                                             input logic [2:0] off,
                                             input int         nb);
        logic [8:0] ones;
        ones = (9'd1 << (4'd1 << size)) - 9'd1;
        return 8'((ones << off) & ((9'd1 << nb) - 9'd1));
    endfunction

    function automatic logic is_aligned(input logic [1:0] size,
                                        input logic [2:0] off);
        logic [2:0] m;
        m = 3'((4'd1 << size) - 4'd1);
        return (off & m) == 3'd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_if.sv
`default_nettype none
// ============================================================================
// dmem_if : request/response handshake bundle for dmem_port
// Rev 1.0  : initial release
// ============================================================================
interface dmem_if #(
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [31:0]       req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              busy;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/dmem_load_align.sv
`default_nettype none
// ============================================================================
// dmem_load_align : extracts and extends a load result from the raw RAM word
// Rev 1.0  : initial release
// ============================================================================
module dmem_load_align #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_raw,
    input  logic [2:0]        i_off,
    input  logic [1:0]        i_size,
    input  logic              i_signed,
    input  logic              i_we,
    input  logic              i_err,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] w_shift;
    logic [DATA_W-1:0] w_low;
    logic [DATA_W-1:0] w_top;
    logic [6:0]        w_nbits;
    logic              w_msb;

    always_comb begin
        w_shift = i_raw >> {i_off, 3'b000};
        w_nbits = 7'd8 << i_size;
        if (w_nbits >= 7'(DATA_W)) begin
            w_low = '1;
        end else begin
            w_low = (DATA_W'(1) << w_nbits) - DATA_W'(1);
        end
        // Top set bit of the keep-mask marks the sign position of the access.
        w_top = w_low & ~(w_low >> 1);
        w_msb = |(w_shift & w_top);
        o_rdata = (w_shift & w_low) | ((i_signed & w_msb) ? ~w_low : '0);
        if (i_we || i_err) begin
            o_rdata = '0;
        end
    end
endmodule
`default_nettype wire

// File: rtl/dmem_port.sv
`default_nettype none
// ============================================================================
// dmem_port : single-port data RAM with byte steering, range/alignment checks
//             and an RD_LAT-deep in-order read pipeline with backpressure
// Rev 1.0   : initial release
// ============================================================================
module dmem_port
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32,  // 32 or 64
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 1    // 1..3
) (
    input  logic  clk,
    input  logic  rst,
    dmem_if.slave bus
);
    localparam int c_nb   = DATA_W / 8;
    localparam int c_offw = $clog2(c_nb);
    localparam int c_last = RD_LAT - 1;

    logic [2:0]        w_off;
    logic [ADDR_W-1:0] w_idx;
    logic              w_oor;
    logic              w_mis;
    logic              w_ill;
    logic              w_err;
    logic              w_adv;
    logic              w_accept;
    logic              w_wr;
    logic [7:0]        w_mask_full;
    logic [c_nb-1:0]   w_mask;
    logic              w_unused_mask;
    logic [DATA_W-1:0] w_wdata_rep;
    logic [DATA_W-1:0] w_ld_data;
    logic              w_busy;

    dmem_stage_t       ctl_q [RD_LAT];
    dmem_stage_t       ctl_d [RD_LAT];
    logic [DATA_W-1:0] raw_q [RD_LAT];
    logic [DATA_W-1:0] raw_d [RD_LAT];
    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    // ---------------- request decode ----------------
    assign w_off    = 3'(bus.req_addr[c_offw-1:0]);
    assign w_idx    = bus.req_addr[ADDR_W+c_offw-1:c_offw];
    assign w_oor    = |(bus.req_addr >> (ADDR_W + c_offw));
    assign w_mis    = !is_aligned(bus.req_size, w_off);
    assign w_ill    = bus.req_size > 2'(c_offw);
    assign w_err    = w_oor | w_mis | w_ill;

    assign w_adv    = !ctl_q[c_last].vld | bus.rsp_ready;
    assign w_accept = bus.req_valid & w_adv & !rst;
    assign w_wr     = w_accept & bus.req_we & !w_err;

    assign w_mask_full   = lane_mask(bus.req_size, w_off, c_nb);
    assign w_mask        = w_mask_full[c_nb-1:0];
    assign w_unused_mask = &{1'b0, w_mask_full};

    // Right-justified store data repeated so every lane sees its own byte.
    always_comb begin
        w_wdata_rep = '0;
        for (int i = 0; i < c_nb; i++) begin
            case (bus.req_size)
                SZ_B:    w_wdata_rep[8*i +: 8] = bus.req_wdata[7:0];
                SZ_H:    w_wdata_rep[8*i +: 8] = bus.req_wdata[8*(i%2) +: 8];
                SZ_W:    w_wdata_rep[8*i +: 8] = bus.req_wdata[8*(i%4) +: 8];
                default: w_wdata_rep[8*i +: 8] = bus.req_wdata[8*i +: 8];
            endcase
        end
    end

    // ---------------- RAM array ----------------
    always_ff @(posedge clk) begin
        if (w_wr) begin
            for (int i = 0; i < c_nb; i++) begin
                if (w_mask[i]) begin
                    mem_q[w_idx][8*i +: 8] <= w_wdata_rep[8*i +: 8];
                end
            end
        end
    end

    // ---------------- read pipeline ----------------
    always_comb begin
        ctl_d[0].vld  = w_accept;
        ctl_d[0].err  = w_err;
        ctl_d[0].we   = bus.req_we;
        ctl_d[0].size = bus.req_size;
        ctl_d[0].sgn  = bus.req_signed;
        ctl_d[0].off  = w_off;
        raw_d[0]      = mem_q[w_idx];
        for (int i = 1; i < RD_LAT; i++) begin
            ctl_d[i] = ctl_q[i-1];
            raw_d[i] = raw_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                ctl_q[i] <= '0;
            end
        end else if (w_adv) begin
            ctl_q <= ctl_d;
        end
    end

    // Raw words need no reset: they are only observed behind a valid bit.
    always_ff @(posedge clk) begin
        if (w_adv) begin
            raw_q <= raw_d;
        end
    end

    // ---------------- response ----------------
    dmem_load_align #(
        .DATA_W (DATA_W)
    ) u_load_align (
        .i_raw    (raw_q[c_last]),
        .i_off    (ctl_q[c_last].off),
        .i_size   (ctl_q[c_last].size),
        .i_signed (ctl_q[c_last].sgn),
        .i_we     (ctl_q[c_last].we),
        .i_err    (ctl_q[c_last].err),
        .o_rdata  (w_ld_data)
    );

    always_comb begin
        w_busy = 1'b0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_busy = w_busy | ctl_q[i].vld;
        end
    end

    assign bus.req_ready = w_adv & !rst;
    assign bus.rsp_valid = ctl_q[c_last].vld;
    assign bus.rsp_err   = ctl_q[c_last].vld & ctl_q[c_last].err;
    assign bus.rsp_rdata = ctl_q[c_last].vld ? w_ld_data : '0;
    assign bus.busy      = w_busy;

endmodule
`default_nettype wire

// File: doc/dmem_port.md
Name: dmem_port

Overview:
- Parametrised single-port data-memory block for the MIPS pipeline MEM stage; replaces the fixed 32-bit byte-enable data RAM.
- Owns the RAM array, byte-lane steering, alignment and range checking, load extraction with sign/zero extension, a configurable read pipeline, and a valid/ready handshake with response backpressure.
- Every accepted request returns exactly one in-order response.

Parameters:
- DATA_W, 32: word width in bits; must be 32 or 64; NB = DATA_W/8 byte lanes.
- ADDR_W, 10: word-index bits; depth = 2^ADDR_W words.
- RD_LAT, 1: request-to-response latency in cycles; legal range 1..3.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block accepts a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  log2 of access bytes: 0 = byte, 1 = half, 2 = word, 3 = dword (dword legal only when DATA_W = 64).
- req_signed  in  1  loads only: sign-extend (1) or zero-extend (0).
- req_addr  in  32  byte address.
- req_wdata  in  DATA_W  store data, right-justified.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  DATA_W  load result, extended; 0 for stores and errors.
- rsp_err  out  1  misaligned, illegal size or out-of-range access.
- busy  out  1  any pipeline stage valid.

Behaviour:
- Pipeline: RD_LAT stages, S1..S_RD_LAT. Each stage holds valid, err, we, size, signed, byte offset and raw word.
- adv = !vld[last] | rsp_ready. When adv = 1, all stages shift by one.
- req_ready = adv (combinational). Accept = req_valid & req_ready.
- Address decode:
  - off = req_addr[log2(NB)-1:0].
  - idx = req_addr[ADDR_W+log2(NB)-1:log2(NB)].
  - Out of range when any req_addr bit above idx is 1.
  - Misaligned when off is not a multiple of 2^req_size.
  - Illegal when req_size > log2(NB).
- On accept:
  - Error: no array access; S1 gets err = 1.
  - Legal store: lane mask = ((1 << 2^size) - 1) << off. Data = req_wdata replicated across lanes. Masked lanes of mem[idx] are written on this edge.
  - Legal load: S1 raw word <= mem[idx] (registered read).
- Ordering: a store accepted at cycle N is visible to a load accepted at cycle N+1 or later. There is only one request per cycle, so no same-cycle read/write.
- Output stage, combinational from the last stage:
  - Shift raw word right by 8*off.
  - Keep the low 8*2^size bits.
  - Extend per the signed bit.
  - Force rsp_rdata to 0 when we or err is set.
- Backpressure: while rsp_valid & !rsp_ready, every stage holds, req_ready = 0, and rsp_* stay stable.
- Bubbles: with RD_LAT > 1, an empty last stage lets the pipeline advance, so bubbles collapse.
- Reset: all valid bits cleared; rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, busy = 0.
  - Array contents are not cleared.
  - In-flight responses are discarded.
  - A request presented in the reset cycle is not accepted and performs no write.
- Throughput: one request per cycle while rsp_ready = 1.

Decomposition:
- Package dmem_pkg holds:
  - size encodings SZ_B, SZ_H, SZ_W, SZ_D;
  - function lane_mask(size, off, NB);
  - function is_aligned(size, off);
  - the pipeline-stage struct type.
- Sub-module dmem_load_align: combinational shift, mask and extend from (raw word, off, size, signed, we, err) to rsp_rdata.
- The array and stage registers live in dmem_port.

Test Plan:
- Store and reload, DATA_W = 32, RD_LAT = 1: sw 0x8000_00FF @0x10, then lw @0x10 → rsp_rdata = 0x8000_00FF after 1 cycle; lb @0x13 → 0xFFFF_FF80; lbu @0x13 → 0x0000_0080; lh @0x12 → 0xFFFF_8000.
- Byte lanes: sw 0x1122_3344 @0x20, sb 0xAA @0x21, sh 0xBEEF @0x22 → lw @0x20 = 0xBEEF_AA44.
- Errors: lw @0x22 → rsp_err = 1, rsp_rdata = 0. sh 0x1234 @0x21 → rsp_err = 1 and memory unchanged. Access @0x0000_1000 with ADDR_W = 10 → rsp_err = 1.
- Backpressure, RD_LAT = 3: issue 4 back-to-back loads, hold rsp_ready = 0 for 5 cycles → req_ready drops once the last stage is valid; all 4 responses then arrive in order with correct data and none are lost or duplicated.
- Reset mid-flight: 2 loads in flight, assert rst for one cycle → rsp_valid = 0 and busy = 0 on the next cycle; previously stored data is still readable afterwards.
- DATA_W = 64: sd 0x0123_4567_89AB_CDEF @0x8, then lw signed @0xC → 0x0000_0000_0123_4567. sd @0x4 → rsp_err = 1.
